// File: rtl/lut_rd_arbiter.sv
// Round-robin arbiter sharing one combinational weight ROM among NUM_REQ channels.
// One lookup is granted per cycle into a single backpressured response register.
module lut_rd_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [8*NUM_REQ-1:0]  i_req_addr,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic [7:0]            o_lut_addr,
  input  logic [23:0]           i_lut_dout,
  output logic                  o_rsp_valid,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [23:0]           o_rsp_data,
  input  logic                  i_rsp_ready
);

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 24;

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              can_issue;
  logic              gnt_any;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   idx;
  logic [ADDR_W-1:0] req_addr [NUM_REQ];

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_addr[k] = i_req_addr[ADDR_W*k +: ADDR_W];
    end
  end

  // Slot is free when empty or draining this cycle.
  assign can_issue = !rsp_valid_q || i_rsp_ready;

  // First valid requester in search order starting at ptr_q wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    if (!i_rst && can_issue) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        idx = ID_W'((32'(ptr_q) + off) % NUM_REQ);
        if (!gnt_any && i_req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = idx;
        end
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    o_lut_addr  = '0;
    if (gnt_any) begin
      o_req_ready[gnt_id] = 1'b1;
      o_lut_addr          = req_addr[gnt_id];
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (gnt_any) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_id;
      rsp_data_d  = i_lut_dout;
      ptr_d       = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end else if (rsp_valid_q && i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_data  = rsp_data_q;

endmodule

// File: doc/lut_rd_arbiter.md
# lut_rd_arbiter

Round-robin arbiter that shares one radial-difference weight ROM (8-bit address, 24-bit combinational read data) between several MRELBP feature channels. Each channel issues address lookups over a valid/ready handshake; the arbiter grants one lookup per cycle, drives the ROM address, and registers the returned weight together with the requester ID. A single output register with backpressure sits between the ROM and the downstream histogram/accumulate stage.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2–8.
- `ID_W`, 2: width of the requester ID; equals ceil(log2(`NUM_REQ`)).
- `i_clk`  in  1: single clock; all logic is rising-edge.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_req_valid`  in  `NUM_REQ`: per-requester lookup request.
- `i_req_addr`  in  8*`NUM_REQ`: packed addresses; requester k uses bits [8k+7:8k].
- `o_req_ready`  out  `NUM_REQ`: one-hot grant; a lookup transfers when valid and ready are both high.
- `o_lut_addr`  out  8: address to the weight ROM.
- `i_lut_dout`  in  24: ROM data, combinational from `o_lut_addr`.
- `o_rsp_valid`  out  1: response register holds data.
- `o_rsp_id`  out  `ID_W`: index of the requester that owns the response.
- `o_rsp_data`  out  24: weight value.
- `i_rsp_ready`  in  1: downstream accepts the response.

## Operation
- Round-robin pointer `ptr` (`ID_W` bits) gives the highest-priority requester. Search order: ptr, ptr+1, … wrapping at `NUM_REQ`-1 to 0.
- `can_issue` = !o_rsp_valid || i_rsp_ready. The response slot is either empty or is draining this cycle.
- Grant: if `can_issue` is high, the first requester in search order with valid high gets `o_req_ready[k]`=1. All other ready bits are 0. This is combinational from the current valids, ptr and can_issue.
- If `can_issue` is low, all ready bits are 0 and no grant happens.
- `o_lut_addr` = i_req_addr of the granted requester. When there is no grant it is 8'h00.
- On a grant to requester k, at the next edge:
  - o_rsp_valid <= 1
  - o_rsp_id <= k
  - o_rsp_data <= i_lut_dout
  - ptr <= (k+1) mod `NUM_REQ`
- With no grant and o_rsp_valid && i_rsp_ready: o_rsp_valid <= 0. The id and data registers hold their values.
- With no grant and the response stalled (valid && !ready): all response registers hold.
- ptr changes only on a grant.
- Simultaneous drain and grant in one cycle: the new response replaces the old one and o_rsp_valid stays 1. No bubble, no loss.
- A request that is valid but not granted stays pending. Requesters must hold valid and addr stable until ready. The arbiter does not check this.
- Fairness: each continuously-requesting channel is granted at least once every `NUM_REQ` grants.

## Timing
- Reset (i_rst high at an edge):
  - ptr = 0
  - o_rsp_valid = 0
  - o_rsp_id = 0
  - o_rsp_data = 24'h0
- During reset, o_req_ready is forced to all-0 and o_lut_addr to 0.
- Reset while the response is stalled discards that response.
- Latency: a grant in cycle N makes the response visible on o_rsp_* in cycle N+1.
- Throughput: one lookup per cycle while i_rsp_ready stays high.
- Backpressure: when i_rsp_ready is low with a response held, no grants happen until i_rsp_ready returns high. Grant resumes in that same cycle.
- The combinational path is i_req_valid/i_req_addr → o_lut_addr → ROM → response register. The ROM read must fit in one cycle.

## Test plan
- Reset then idle: hold i_rst for 2 cycles with all valids high.
  - During reset: ready = 0, rsp_valid = 0.
  - First cycle after reset: grant to req0, o_lut_addr = req0 addr.
- Single requester: req2 valid with addr 8'h05, ROM[5] = 24'hABCDEF.
  - ready[2] rises in the same cycle.
  - Next cycle: rsp_valid = 1, rsp_id = 2, rsp_data = 24'hABCDEF.
- All 4 requesters continuously valid with addrs 10/20/30/40 and i_rsp_ready = 1.
  - Grant order: 0,1,2,3,0,…
  - rsp_ids follow one cycle later with no bubbles.
  - Data matches ROM[10], ROM[20], ROM[30], ROM[40].
- Backpressure: drop i_rsp_ready for 3 cycles while a response for id 1 is held.
  - rsp_id/rsp_data stay stable and ready stays all-0 for those cycles.
  - On the cycle ready returns, the next grant goes to id 2.
- Wrap/fairness: ptr = 3 with requesters 0 and 3 valid.
  - Grant order: 3 then 0.
  - Each requester is granted within every 4 consecutive grants.
- Mid-stall reset: assert i_rst while rsp_valid = 1 and i_rsp_ready = 0.
  - Next cycle: rsp_valid = 0, rsp_id = 0, rsp_data = 0, ptr restarts at 0.
